input_frame_conditioner: RTL and testbench
==========================================

Name: input_frame_conditioner

Overview:
- Sits directly upstream of the player FSM.
- Takes raw gamepad button levels (up, down, left, right, attack) from the controller decoder, synchronises and debounces them, and collects press events across a video frame.
- Presents a stable 5-bit command word that changes only at frame_end.
- Adds auto-repeat for held directions so the player keeps moving while a direction is held. Attack fires once per press.

Parameters:
- DEBOUNCE_CYCLES, 1024: consecutive identical synchronised samples required before a debounced level changes (min 2).
- REPEAT_DELAY, 12: frames a direction must stay held after its press before the first auto-repeat (min 1).
- REPEAT_RATE, 6: frames between successive auto-repeats once repeating (min 1).

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  asynchronous, active-high; clears all state
- raw_buttons  in  5  asynchronous button levels, 1 = pressed: [0] up, [1] down, [2] left, [3] right, [4] attack
- frame_end  in  1  one-cycle pulse at end of each frame, synchronous to clk
- input_data  out  5  conditioned command word, same bit map as raw_buttons; held for one full frame
- input_valid  out  1  one-cycle pulse, the cycle after input_data updates
- buttons_held  out  5  current debounced levels

Behaviour:
- Reset: input_data=0, input_valid=0, buttons_held=0; synchroniser, debounce counters, sticky events and repeat counters all cleared. Reset asserted mid-frame discards all pending events.
- Synchroniser: 2-FF per bit on raw_buttons → s[4:0].
- Debounce, per bit:
  - Counter of width clog2(DEBOUNCE_CYCLES)+1.
  - If s != buttons_held: counter increments. When it reaches DEBOUNCE_CYCLES-1, buttons_held flips and the counter clears.
  - If s == buttons_held: counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes buttons_held.
- Press event: rising edge of buttons_held[i] (registered previous value) sets sticky[i].
- Frame commit, on a frame_end cycle:
  - input_data <= resolve(sticky | repeat_fire).
  - sticky <= the press events of that same cycle only. An event coincident with frame_end lands in the next frame, not this one.
  - Next cycle: input_valid=1.
- Between frame_end pulses, input_data is constant.
- A press and release within one frame still produces exactly one committed bit.
- Auto-repeat, directions [3:0] only; per-direction frame counter of width clog2(max(REPEAT_DELAY,REPEAT_RATE))+1:
  - Counter resets to 0 on the press event and whenever buttons_held[i]=0.
  - Counter advances by 1 on each frame_end while held.
  - repeat_fire[i]=1 at the frame_end where the count equals REPEAT_DELAY. Counter then reloads so the next fire occurs after REPEAT_RATE more frame_ends, and so on.
  - Attack [4] never repeats.
- resolve():
  - If up and down are both set, both are cleared.
  - If left and right are both set, both are cleared.
  - Attack passes through unchanged.
  - Resolution acts on the committed word only; sticky is unaffected.
- Latency:
  - raw edge → buttons_held: 2 + DEBOUNCE_CYCLES clk.
  - buttons_held edge → input_data: the next frame_end, +1 clk register.
- frame_end asserted on consecutive cycles: each cycle is a full commit. Legal, but not expected.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=3, REPEAT_RATE=2, frame_end every 20 clk):
- Reset release, raw_buttons=0 → input_data=0, buttons_held=0, and input_valid pulses once per frame_end with data 0.
- Up (raw=00001) held 10 clk mid-frame, then released → buttons_held[0] rises 6 clk after raw edge; next commit input_data=00001; the following commit input_data=00000.
- 3-clk pulse on attack (raw=10000) → buttons_held stays 0 and every commit is 00000.
- Right (raw=01000) held for 9 frames → commits at frame_end k=1..9: 01000, 0, 0, 01000, 0, 01000, 0, 01000, 0.
- Left and right pressed together (raw=01100) plus attack → committed input_data=10000. Then release right only → left repeats per the schedule above.
- Down press whose debounced edge coincides with a frame_end cycle → that commit excludes it (00000); the next commit = 00010. Asserting reset during a frame with sticky=00010 → after reset release the commit is 00000.

Source files
------------

// File: rtl/input_frame_conditioner.sv
// Gamepad front end: synchronise, debounce, latch presses per frame and add
// auto-repeat on held directions; the command word changes only at frame_end.
module input_frame_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int REPEAT_DELAY    = 12,
    parameter int REPEAT_RATE     = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] raw_buttons,
    input  logic       frame_end,
    output logic [4:0] input_data,
    output logic       input_valid,
    output logic [4:0] buttons_held
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W = $clog2(RPT_MAX) + 1;
    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_C = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_RATE_C  = RPT_W'(REPEAT_RATE);

    logic [4:0]       r_sync1;
    logic [4:0]       r_sync2;
    logic [CNT_W-1:0] r_db_cnt [5];
    logic [4:0]       r_held;
    logic [4:0]       r_held_d;
    logic [4:0]       r_sticky;
    logic [RPT_W-1:0] r_rpt_cnt [4];
    logic [3:0]       r_rpt_on;
    logic [4:0]       r_data;
    logic             r_valid;
    logic [4:0]       w_press;
    logic [3:0]       w_fire;

    // Opposing directions cancel in the committed word only.
    function automatic logic [4:0] resolve(input logic [4:0] w);
        logic [4:0] r;
        r = w;
        if (w[0] && w[1]) r[1:0] = 2'b00;
        if (w[2] && w[3]) r[3:2] = 2'b00;
        return r;
    endfunction

    // Stage: two-flop synchroniser
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= raw_buttons;
            r_sync2 <= r_sync1;
        end
    end

    // Stage: debounce, level flips after DEBOUNCE_CYCLES mismatching samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 5; i++) r_db_cnt[i] <= '0;
            r_held   <= '0;
            r_held_d <= '0;
        end else begin
            r_held_d <= r_held;
            for (int i = 0; i < 5; i++) begin
                if (r_sync2[i] != r_held[i]) begin
                    if (r_db_cnt[i] == DB_LAST) begin
                        r_held[i]   <= ~r_held[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_press = r_held & ~r_held_d;

    // First fire waits REPEAT_DELAY frames, later fires every REPEAT_RATE frames.
    always_comb begin
        w_fire = '0;
        for (int i = 0; i < 4; i++) begin
            w_fire[i] = frame_end && r_held[i] && !w_press[i] &&
                        (r_rpt_on[i] ? (r_rpt_cnt[i] == RPT_RATE_C)
                                     : (r_rpt_cnt[i] == RPT_DELAY_C));
        end
    end

    // Stage: per-direction repeat frame counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) r_rpt_cnt[i] <= '0;
            r_rpt_on <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!r_held[i] || w_press[i]) begin
                    r_rpt_cnt[i] <= '0;
                    r_rpt_on[i]  <= 1'b0;
                end else if (w_fire[i]) begin
                    r_rpt_cnt[i] <= RPT_W'(1);
                    r_rpt_on[i]  <= 1'b1;
                end else if (frame_end) begin
                    r_rpt_cnt[i] <= r_rpt_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Stage: frame commit; presses on the commit cycle roll into the next frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sticky <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= frame_end;
            if (frame_end) begin
                r_data   <= resolve(r_sticky | {1'b0, w_fire});
                r_sticky <= w_press;
            end else begin
                r_sticky <= r_sticky | w_press;
            end
        end
    end

    assign input_data   = r_data;
    assign input_valid  = r_valid;
    assign buttons_held = r_held;

endmodule

// File: tb/tb_input_frame_conditioner.sv
// Bench for input_frame_conditioner: directed frame table, a reset-mid-frame
// sequence, and randomized traffic against a behavioural model.
module tb_input_frame_conditioner;

    localparam int DEBOUNCE_CYCLES = 4;
    localparam int REPEAT_DELAY    = 3;
    localparam int REPEAT_RATE     = 2;
    localparam int FRAME           = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] raw_buttons = '0;
    logic       frame_end = 1'b0;
    logic [4:0] input_data;
    logic       input_valid;
    logic [4:0] buttons_held;

    int checks = 0;
    int failures = 0;

    input_frame_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE(REPEAT_RATE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .raw_buttons(raw_buttons),
        .frame_end(frame_end),
        .input_data(input_data),
        .input_valid(input_valid),
        .buttons_held(buttons_held)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] r0;
        int         s1;
        logic [4:0] r1;
        int         s2;
        logic [4:0] r2;
        int         chk_c;
        logic [4:0] exp_mid;
        logic [4:0] exp_data;
        logic [4:0] exp_held;
    } frame_vec_t;

    frame_vec_t vecs [25];

    // Behavioural model state: levels, run lengths and frames-held counts.
    logic [4:0] m_sync1, m_s, m_held, m_prev, m_sticky, m_data;
    logic       m_valid;
    int         m_run [5];
    int         m_frames [4];

    function automatic logic [4:0] m_resolve(input logic [4:0] w);
        logic [4:0] r;
        r = w;
        if (w[0] && w[1]) r[1:0] = 2'b00;
        if (w[2] && w[3]) r[3:2] = 2'b00;
        return r;
    endfunction

    task automatic model_reset();
        m_sync1 = '0; m_s = '0; m_held = '0; m_prev = '0;
        m_sticky = '0; m_data = '0; m_valid = 1'b0;
        for (int i = 0; i < 5; i++) m_run[i] = 0;
        for (int i = 0; i < 4; i++) m_frames[i] = 0;
    endtask

    // Advances the model by one clock using the inputs about to be sampled.
    task automatic model_step(input logic [4:0] raw, input logic fe);
        logic [4:0] press;
        logic [4:0] fire;
        press = m_held & ~m_prev;
        fire = '0;
        for (int i = 0; i < 4; i++) begin
            if (fe && m_held[i] && !press[i] && m_frames[i] >= REPEAT_DELAY &&
                ((m_frames[i] - REPEAT_DELAY) % REPEAT_RATE) == 0)
                fire[i] = 1'b1;
        end
        m_valid = fe;
        if (fe) begin
            m_data = m_resolve(m_sticky | fire);
            m_sticky = press;
        end else begin
            m_sticky = m_sticky | press;
        end
        for (int i = 0; i < 4; i++) begin
            if (!m_held[i] || press[i]) m_frames[i] = 0;
            else if (fe) m_frames[i] = m_frames[i] + 1;
        end
        m_prev = m_held;
        for (int i = 0; i < 5; i++) begin
            if (m_s[i] != m_held[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == DEBOUNCE_CYCLES) begin
                    m_held[i] = ~m_held[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s = m_sync1;
        m_sync1 = raw;
    endtask

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        if (!reset) begin
            chk("model_data", input_data, m_data);
            chk("model_valid", {4'b0, input_valid}, {4'b0, m_valid});
            chk("model_held", buttons_held, m_held);
        end
    endtask

    task automatic cyc(input logic [4:0] r, input logic fe);
        raw_buttons = r;
        frame_end = fe;
        model_step(r, fe);
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic run_frame(input frame_vec_t v, input int idx);
        logic [4:0] r;
        for (int c = 0; c < FRAME; c++) begin
            r = (c < v.s1) ? v.r0 : ((c < v.s2) ? v.r1 : v.r2);
            cyc(r, c == FRAME - 1);
            if (c == v.chk_c) chk($sformatf("f%0d_mid_held", idx), buttons_held, v.exp_mid);
        end
        chk($sformatf("f%0d_data", idx), input_data, v.exp_data);
        chk($sformatf("f%0d_valid", idx), {4'b0, input_valid}, 5'd1);
        chk($sformatf("f%0d_held", idx), buttons_held, v.exp_held);
    endtask

    function automatic frame_vec_t mk(input logic [4:0] r0, input int s1, input logic [4:0] r1,
                                      input int s2, input logic [4:0] r2, input int chk_c,
                                      input logic [4:0] exp_mid, input logic [4:0] exp_data,
                                      input logic [4:0] exp_held);
        frame_vec_t v;
        v.r0 = r0; v.s1 = s1; v.r1 = r1; v.s2 = s2; v.r2 = r2;
        v.chk_c = chk_c; v.exp_mid = exp_mid; v.exp_data = exp_data; v.exp_held = exp_held;
        return v;
    endfunction

    function automatic frame_vec_t steady(input logic [4:0] r, input logic [4:0] exp_data);
        return mk(r, 0, r, FRAME, r, -1, 5'b0, exp_data, r);
    endfunction

    initial begin
        logic [4:0] rr;
        int len;

        vecs[0]  = steady(5'b00000, 5'b00000);
        vecs[1]  = mk(5'b00000, 2, 5'b00001, 12, 5'b00000, 7, 5'b00001, 5'b00001, 5'b00000);
        vecs[2]  = steady(5'b00000, 5'b00000);
        vecs[3]  = mk(5'b00000, 5, 5'b10000, 8, 5'b00000, 12, 5'b00000, 5'b00000, 5'b00000);
        vecs[4]  = steady(5'b00000, 5'b00000);
        vecs[5]  = mk(5'b00000, 2, 5'b01000, FRAME, 5'b01000, 7, 5'b01000, 5'b01000, 5'b01000);
        vecs[6]  = steady(5'b01000, 5'b00000);
        vecs[7]  = steady(5'b01000, 5'b00000);
        vecs[8]  = steady(5'b01000, 5'b01000);
        vecs[9]  = steady(5'b01000, 5'b00000);
        vecs[10] = steady(5'b01000, 5'b01000);
        vecs[11] = steady(5'b01000, 5'b00000);
        vecs[12] = steady(5'b01000, 5'b01000);
        vecs[13] = steady(5'b01000, 5'b00000);
        vecs[14] = mk(5'b00000, 0, 5'b00000, FRAME, 5'b00000, 4, 5'b01000, 5'b00000, 5'b00000);
        vecs[15] = mk(5'b00000, 2, 5'b11100, FRAME, 5'b11100, 7, 5'b11100, 5'b10000, 5'b11100);
        vecs[16] = mk(5'b10100, 0, 5'b10100, FRAME, 5'b10100, 5, 5'b10100, 5'b00000, 5'b10100);
        vecs[17] = steady(5'b10100, 5'b00000);
        vecs[18] = steady(5'b10100, 5'b00100);
        vecs[19] = steady(5'b10100, 5'b00000);
        vecs[20] = steady(5'b10100, 5'b00100);
        vecs[21] = steady(5'b00000, 5'b00000);
        vecs[22] = mk(5'b00000, 13, 5'b00010, FRAME, 5'b00010, 18, 5'b00010, 5'b00000, 5'b00010);
        vecs[23] = steady(5'b00010, 5'b00010);
        vecs[24] = steady(5'b00000, 5'b00000);

        #1;
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_data", input_data, 5'b0);
        chk("rst_valid", {4'b0, input_valid}, 5'b0);
        chk("rst_held", buttons_held, 5'b0);

        for (int k = 0; k < 25; k++) run_frame(vecs[k], k);

        // Down pressed mid-frame, then reset before the frame commits.
        for (int c = 0; c < 10; c++) cyc((c < 2) ? 5'b00000 : 5'b00010, 1'b0);
        chk("pre_rst_held", buttons_held, 5'b00010);
        raw_buttons = '0;
        frame_end = 1'b0;
        reset = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_data", input_data, 5'b0);
        chk("mid_rst_held", buttons_held, 5'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < FRAME; c++) cyc(5'b00000, c == FRAME - 1);
        chk("post_rst_data", input_data, 5'b0);
        chk("post_rst_valid", {4'b0, input_valid}, 5'd1);

        // Random levels, glitches, long holds and irregular frame_end spacing.
        for (int n = 0; n < 3000; n += len) begin
            rr = 5'($urandom_range(0, 31));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 120) : $urandom_range(1, 8);
            for (int j = 0; j < len; j++) cyc(rr, $urandom_range(0, 9) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
